fa_serial_seq: RTL and testbench
================================

Name: fa_serial_seq

Overview:
- Bit-serial N-bit adder/subtractor sequencer built around one instance of the team's one-bit full-adder cell, fa_case (ports s, co, a, b, ci).
- Latches two N-bit operands on a start request and feeds them LSB-first through the single full-adder cell, one bit per clock.
- Holds the carry in a flip-flop between bits and assembles the result in a shift register.
- Lets small datapaths share one adder cell instead of instantiating N full adders.

Parameters:
- N, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(N), bit counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = add, 1 = subtract (a - b); latched at accept
- a  input  N  operand A; latched at accept
- b  input  N  operand B; latched at accept
- ci  input  1  carry-in for add; ignored when sub=1; latched at accept
- busy  output  1  high while operation in progress
- done  output  1  one-cycle completion pulse
- sum  output  N  result; valid from done, held until next completion
- co  output  1  carry-out (in subtract mode: 1 = no borrow)
- ovf  output  1  signed overflow of the completed operation

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, busy=0, done=0, sum=0, co=0, ovf=0.
  - Carry register, counter and shift registers cleared.
  - An in-flight operation is discarded; no done pulse.
- IDLE:
  - start=1 at edge k: latch a_sh=a, b_sh = sub ? ~b : b, carry = sub ? 1 : ci, cnt=0; go to RUN.
  - busy=1 from edge k.
- RUN, each cycle:
  - Full-adder inputs: a_sh[0], b_sh[0], carry.
  - At the edge: a_sh and b_sh shift right; fa_case s shifts into the MSB of the result shift register; carry <= fa_case co; cnt++.
  - At the last bit (cnt==N-1): also capture c_msb_in = carry before the update, for overflow.
  - After N RUN cycles (edge k+N): sum <= assembled result, co <= final carry, ovf <= c_msb_in XOR final carry; go to DONE.
- DONE:
  - busy=0, done=1 for exactly this one cycle (cycle after edge k+N); next edge returns to IDLE.
- Latency: start accepted at edge k -> done high during the cycle following edge k+N. Minimum issue interval is N+2 cycles.
- start while in RUN or DONE: ignored; no queuing. a, b, sub and ci may change freely after accept without effect.
- sum, co and ovf change only at the RUN->DONE edge or on reset; they are stable between operations.
- Arithmetic is modulo 2^N. co is the true carry-out of bit N-1. In subtract mode co=1 iff a >= b (unsigned).

Test Plan:
- N=8, add, a=0x5A, b=0x33, ci=0, start at edge 0 -> busy edges 0..8, done in cycle after edge 8, sum=0x8D, co=0, ovf=1.
- Add a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1, ovf=0. Add a=0x7F, b=0x00, ci=1 -> sum=0x80, co=0, ovf=1.
- Subtract a=0x10, b=0x20, ci=1 (must be ignored) -> sum=0xF0, co=0, ovf=0. Subtract a=0x80, b=0x01 -> sum=0x7F, co=1, ovf=1.
- Pulse start with different operands at RUN cycle 3 and again in DONE -> first result unaffected; no second operation begins; exactly one done pulse.
- Assert rst_n=0 asynchronously mid-RUN (cycle 4) -> all outputs 0 immediately, no done. After release, a new start completes normally with a correct result.
- Back-to-back: start held high continuously -> operations accepted every N+2 cycles, one done pulse per operation, and each result matches its latched operands.

Source files
------------

// File: rtl/fa_serial_seq_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fa_serial_seq_if
// Request/result bundle for the bit-serial adder/subtractor sequencer.
//   start, sub, a, b, ci : request side (driven by the master)
//   busy, done, sum, co, ovf : status/result side (driven by the sequencer)
// Modports:
//   master : requester view (testbench or client datapath)
//   slave  : sequencer view (fa_serial_seq)
// ----------------------------------------------------------------------------
interface fa_serial_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, sum, co, ovf
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, sum, co, ovf
    );
endinterface

// File: rtl/fa_serial_seq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fa_case
// One-bit full-adder cell.
//   s  : sum output
//   co : carry output
//   a, b, ci : addend bits and carry input
// ----------------------------------------------------------------------------
module fa_case (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);
    // Plain majority/parity full adder.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end
endmodule

// ----------------------------------------------------------------------------
// fa_serial_seq
// Bit-serial N-bit adder/subtractor sharing a single fa_case cell.
// Operands are latched on an accepted start, fed LSB-first one bit per clock,
// and the result is assembled in a shift register. Completion is signalled
// with a one-cycle done pulse; sum/co/ovf hold until the next completion.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave view)
//     start in  : request, sampled only in IDLE
//     sub   in  : 0 = a + b + ci, 1 = a - b (latched at accept)
//     a, b  in  : operands (latched at accept)
//     ci    in  : carry-in for add, ignored for subtract
//     busy  out : operation in progress
//     done  out : one-cycle completion pulse
//     sum   out : result, valid from done
//     co    out : carry-out of bit N-1 (subtract: 1 = no borrow)
//     ovf   out : signed overflow
// ----------------------------------------------------------------------------
module fa_serial_seq #(
    parameter  int N  = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fa_serial_seq_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   a_sh_q,  a_sh_d;
    logic [N-1:0]   b_sh_q,  b_sh_d;
    logic [N-1:0]   res_q,   res_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic [N-1:0]   sum_q,   sum_d;
    logic           co_q,    co_d;
    logic           ovf_q,   ovf_d;

    logic           fa_s;
    logic           fa_co;
    logic [N-1:0]   res_next;

    // The single shared full-adder cell, fed from the operand LSBs.
    fa_case u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q)
    );

    // Result shift register with the current sum bit entering at the MSB.
    always_comb begin
        res_next = {fa_s, res_q[N-1:1]};
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (bus.start) begin
                    // Subtract is a + ~b + 1: invert B and force carry-in.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.ci;
                    res_d   = {N{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[N-1:1]};
                b_sh_d  = {1'b0, b_sh_q[N-1:1]};
                res_d   = res_next;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB; XOR with the
                    // carry out of the MSB gives signed overflow.
                    sum_d   = res_next;
                    co_d    = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= {N{1'b0}};
            b_sh_q  <= {N{1'b0}};
            res_q   <= {N{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {N{1'b0}};
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from flops.
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_fa_serial_seq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_fa_serial_seq
// Directed bench for fa_serial_seq (N=8). Expected results come from an
// arithmetic model, are queued when an operation is accepted and popped when
// done is seen.
// ----------------------------------------------------------------------------
module tb_fa_serial_seq;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fa_serial_seq_if #(.N(N)) bus ();

    fa_serial_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [N-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    // Count every done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    // Reference arithmetic: (N+1)-bit addition, overflow from operand signs.
    function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib,
                                   input logic isub, input logic ici);
        exp_t         r;
        logic [N-1:0] bb;
        logic         cin;
        logic [N:0]   full;
        bb    = isub ? ~ib : ib;
        cin   = isub ? 1'b1 : ici;
        full  = {1'b0, ia} + {1'b0, bb} + {{N{1'b0}}, cin};
        r.sum = full[N-1:0];
        r.co  = full[N];
        r.ovf = (ia[N-1] == bb[N-1]) && (r.sum[N-1] != ia[N-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge and queue its expected result.
    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic isub, input logic ici);
        bus.a     = ia;
        bus.b     = ib;
        bus.sub   = isub;
        bus.ci    = ici;
        bus.start = 1'b1;
        sb_q.push_back(model(ia, ib, isub, ici));
        step();
        bus.start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sbq"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_sum"}, 32'(bus.sum), 32'(e.sum));
            chk({tag, "_co"},  32'(bus.co),  32'(e.co));
            chk({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
        end
    endtask

    // Bounded wait for done, then score the result.
    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < 3 * N) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        check_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ci    = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_co",   32'(bus.co),   32'd0);
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Latency: accepted at edge k, done in the cycle after edge k+N.
        issue(8'h5A, 8'h33, 1'b0, 1'b0);
        chk("lat_busy_k", 32'(bus.busy), 32'd1);
        chk("lat_done_k", 32'(bus.done), 32'd0);
        repeat (N - 1) step();
        chk("lat_busy_kN1", 32'(bus.busy), 32'd1);
        chk("lat_done_kN1", 32'(bus.done), 32'd0);
        step();
        chk("lat_done_kN", 32'(bus.done), 32'd1);
        chk("lat_busy_kN", 32'(bus.busy), 32'd0);
        chk("add5a33_sum_const", 32'(bus.sum), 32'h8D);
        check_result("add5a33");
        step();
        chk("lat_done_off", 32'(bus.done), 32'd0);
        chk("hold_sum", 32'(bus.sum), 32'h8D);

        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done("addff01");
        step();
        issue(8'h7F, 8'h00, 1'b0, 1'b1);
        wait_done("add7f00c");
        step();
        issue(8'h10, 8'h20, 1'b1, 1'b1);
        wait_done("sub1020");
        step();
        issue(8'h80, 8'h01, 1'b1, 1'b0);
        wait_done("sub8001");
        step();

        // start during RUN and DONE must be ignored.
        d0 = done_cnt;
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) step();
        bus.a = 8'hFF; bus.b = 8'hFF; bus.sub = 1'b1; bus.ci = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("ign_run");
        bus.a = 8'h01; bus.b = 8'h02; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ign_done_busy", 32'(bus.busy), 32'd0);
        repeat (N + 2) step();
        chk("ign_busy_late", 32'(bus.busy), 32'd0);
        chk("ign_one_done", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset in the middle of RUN.
        d0 = done_cnt;
        issue(8'h55, 8'h0F, 1'b1, 1'b0);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_sum",  32'(bus.sum),  32'd0);
        chk("mrst_co",   32'(bus.co),   32'd0);
        chk("mrst_ovf",  32'(bus.ovf),  32'd0);
        void'(sb_q.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) step();
        chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
        issue(8'h55, 8'h0F, 1'b1, 1'b0);
        wait_done("after_rst");
        step();

        // Back-to-back with start held high: one accept every N+2 cycles.
        d0 = done_cnt;
        bus.a = 8'hC3; bus.b = 8'h5E; bus.sub = 1'b0; bus.ci = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(model(bus.a, bus.b, bus.sub, bus.ci));
            step();
            chk($sformatf("b2b%0d_busy", i), 32'(bus.busy), 32'd1);
            bus.a   = 8'($urandom_range(0, 255));
            bus.b   = 8'($urandom_range(0, 255));
            bus.sub = 1'($urandom_range(0, 1));
            bus.ci  = 1'($urandom_range(0, 1));
            repeat (N - 1) step();
            chk($sformatf("b2b%0d_notyet", i), 32'(bus.done), 32'd0);
            step();
            chk($sformatf("b2b%0d_done", i), 32'(bus.done), 32'd1);
            check_result($sformatf("b2b%0d", i));
            step();
            chk($sformatf("b2b%0d_idle", i), 32'(bus.busy), 32'd0);
        end
        bus.start = 1'b0;
        step();
        chk("b2b_pulses", 32'(done_cnt - d0), 32'd4);
        chk("sbq_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
